// File: rtl/keccak_squeeze.sv
// Squeeze-side reader of the Keccak sponge state: streams rate lanes as w-bit
// words over valid/ready and requests re-permutation when the rate runs out.
module keccak_squeeze #(
  parameter int STATE_WIDTH = 1600,
  parameter int w           = 64,
  parameter int RATE_LANES  = 21,
  parameter int LEN_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   out_len,
  input  logic [STATE_WIDTH-1:0] state_in,
  input  logic                   state_valid,
  output logic                   state_ready,
  output logic [STATE_WIDTH-1:0] state_out,
  output logic                   perm_req,
  output logic [w-1:0]           dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   dout_last,
  output logic                   busy,
  output logic                   done
);

  localparam int LW = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]             fsm;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [LW-1:0]          lane_idx;
  logic [STATE_WIDTH-1:0] state_q;
  logic                   first_blk;
  logic [w-1:0]           lane_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      remaining <= '0;
      lane_idx  <= '0;
      state_q   <= '0;
      first_blk <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            remaining <= out_len;
            lane_idx  <= '0;
            first_blk <= 1'b1;
            fsm       <= (out_len == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (state_valid) begin
            state_q   <= state_in;
            lane_idx  <= '0;
            first_blk <= 1'b0;
            fsm       <= EMIT;
          end
        end
        EMIT: begin
          if (dout_ready) begin
            remaining <= remaining - LEN_WIDTH'(1);
            lane_idx  <= lane_idx + LW'(1);
            // Final word wins over end-of-rate, so a job ending on a block
            // boundary never triggers a needless permutation.
            if (remaining == LEN_WIDTH'(1))
              fsm <= DONE;
            else if (lane_idx == LW'(RATE_LANES - 1))
              fsm <= LOAD;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  always_comb begin
    lane_word = '0;
    for (int unsigned k = 0; k < RATE_LANES; k++) begin
      if (lane_idx == LW'(k))
        lane_word = state_q[STATE_WIDTH-1-k*w -: w];
    end
  end

  assign state_ready = (fsm == LOAD);
  assign perm_req    = (fsm == LOAD) && !first_blk;
  assign state_out   = state_q;
  assign dout_valid  = (fsm == EMIT);
  assign dout        = dout_valid ? lane_word : '0;
  assign dout_last   = dout_valid && (remaining == LEN_WIDTH'(1));
  assign busy        = (fsm != IDLE);
  assign done        = (fsm == DONE);

endmodule

// File: tb/tb_keccak_squeeze.sv
// Bench for keccak_squeeze: table of jobs checked against a word-list model
// built directly from the lane/block numbering, plus reset corner cases.
module tb_keccak_squeeze;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sel = 1'b0;
  logic [31:0]   out_len = '0;
  logic [1599:0] state_in = '0;
  logic          state_valid = 1'b0;
  logic          dout_ready = 1'b0;

  logic          a_state_ready, a_perm_req, a_dout_valid, a_dout_last, a_busy, a_done;
  logic [1599:0] a_state_out;
  logic [63:0]   a_dout;
  logic          b_state_ready, b_perm_req, b_dout_valid, b_dout_last, b_busy, b_done;
  logic [1599:0] b_state_out;
  logic [63:0]   b_dout;

  logic          s_state_ready, s_perm_req, s_dout_valid, s_dout_last, s_busy, s_done;
  logic [1599:0] s_state_out;
  logic [63:0]   s_dout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  keccak_squeeze #(.STATE_WIDTH(1600), .w(64), .RATE_LANES(21), .LEN_WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .out_len(out_len),
    .state_in(state_in), .state_valid(state_valid), .state_ready(a_state_ready),
    .state_out(a_state_out), .perm_req(a_perm_req), .dout(a_dout),
    .dout_valid(a_dout_valid), .dout_ready(dout_ready), .dout_last(a_dout_last),
    .busy(a_busy), .done(a_done)
  );

  keccak_squeeze #(.STATE_WIDTH(1600), .w(64), .RATE_LANES(17), .LEN_WIDTH(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .out_len(out_len),
    .state_in(state_in), .state_valid(state_valid), .state_ready(b_state_ready),
    .state_out(b_state_out), .perm_req(b_perm_req), .dout(b_dout),
    .dout_valid(b_dout_valid), .dout_ready(dout_ready), .dout_last(b_dout_last),
    .busy(b_busy), .done(b_done)
  );

  always_comb begin
    s_state_ready = sel ? b_state_ready : a_state_ready;
    s_perm_req    = sel ? b_perm_req    : a_perm_req;
    s_dout_valid  = sel ? b_dout_valid  : a_dout_valid;
    s_dout_last   = sel ? b_dout_last   : a_dout_last;
    s_busy        = sel ? b_busy        : a_busy;
    s_done        = sel ? b_done        : a_done;
    s_state_out   = sel ? b_state_out   : a_state_out;
    s_dout        = sel ? b_dout        : a_dout;
  end

  typedef struct {
    int sel;
    int len;
    int rdy;
    bit pat;
    bit poke;
    int loads;
    int perms;
  } job_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_job(input job_t j);
    logic [1599:0] st [4];
    logic [63:0]   exp_q [$];
    int r = (j.sel != 0) ? 17 : 21;
    int nb, loads, perms, widx, cyc, last_hs;
    bit fin, poked;
    nb = (j.len + r - 1) / r;
    loads = 0; perms = 0; widx = 0; cyc = 0; last_hs = -10; fin = 0; poked = 0;
    for (int b = 0; b < 4; b++) begin
      st[b] = '0;
      for (int k = 0; k < 25; k++)
        st[b][1599-k*64 -: 64] = j.pat ? 64'(b*100 + k) : {$urandom, $urandom};
    end
    // Word i comes from block i/r, lane i%r.
    for (int i = 0; i < j.len; i++)
      exp_q.push_back(st[i/r][1599-(i%r)*64 -: 64]);

    @(negedge clk);
    sel = j.sel[0];
    out_len = j.len;
    start = 1'b1;
    @(negedge clk);
    while (!fin && cyc < 3000) begin
      start = 1'b0;
      check("perm_req_outside_load", {63'd0, s_perm_req & ~s_state_ready}, 64'd0);
      if (s_state_ready) begin
        check("perm_req_level", {63'd0, s_perm_req}, {63'd0, loads > 0});
        if (!state_valid) begin
          check("load_in_range", {63'd0, loads < nb}, 64'd1);
          if (loads > 0) begin
            n_tests++;
            if (s_state_out !== st[(loads-1)%4]) begin
              n_fail++;
              $display("FAIL state_out low64 actual=%h required=%h",
                       s_state_out[63:0], st[(loads-1)%4][63:0]);
            end
          end
          if (s_perm_req) perms++;
          state_in = st[loads%4];
          state_valid = 1'b1;
          loads++;
        end
      end else begin
        state_valid = 1'b0;
      end
      if (s_dout_valid) begin
        if (widx < j.len) begin
          check($sformatf("dout[%0d]", widx), s_dout, exp_q[widx]);
          check($sformatf("dout_last[%0d]", widx), {63'd0, s_dout_last},
                {63'd0, widx == j.len - 1});
        end else begin
          check("extra_word", 64'(widx), 64'(j.len - 1));
        end
        dout_ready = ($urandom_range(99) < j.rdy);
        if (dout_ready) begin
          widx++;
          last_hs = cyc;
        end
        if (j.poke && widx == 3 && !poked) begin
          start = 1'b1;
          out_len = 7;
          poked = 1;
        end
      end else begin
        dout_ready = $urandom_range(1) == 1;
      end
      if (s_done) begin
        check("words_emitted", 64'(widx), 64'(j.len));
        check("state_loads", 64'(loads), 64'(j.loads));
        check("perm_blocks", 64'(perms), 64'(j.perms));
        check("busy_in_done", {63'd0, s_busy}, 64'd1);
        if (j.len > 0) check("done_latency", 64'(cyc), 64'(last_hs + 1));
        fin = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("job_finished", {63'd0, fin}, 64'd1);
    start = 1'b0;
    state_valid = 1'b0;
    dout_ready = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {63'd0, s_done}, 64'd0);
    check("idle_after_done", {63'd0, s_busy}, 64'd0);
  endtask

  job_t tbl [12];

  initial begin
    tbl[0]  = '{0,  4, 100, 1'b1, 1'b0, 1, 0};
    tbl[1]  = '{0,  0, 100, 1'b1, 1'b0, 0, 0};
    tbl[2]  = '{0, 25, 100, 1'b1, 1'b0, 2, 1};
    tbl[3]  = '{0, 21,  50, 1'b1, 1'b0, 1, 0};
    tbl[4]  = '{0, 21,  50, 1'b0, 1'b0, 1, 0};
    tbl[5]  = '{0, 43,  70, 1'b0, 1'b0, 3, 2};
    tbl[6]  = '{0,  1, 100, 1'b0, 1'b0, 1, 0};
    tbl[7]  = '{0, 10,  60, 1'b1, 1'b1, 1, 0};
    tbl[8]  = '{0, 42, 100, 1'b0, 1'b0, 2, 1};
    tbl[9]  = '{1, 18, 100, 1'b1, 1'b0, 2, 1};
    tbl[10] = '{1, 34,  40, 1'b0, 1'b0, 2, 1};
    tbl[11] = '{1, 35,  80, 1'b0, 1'b0, 3, 2};

    repeat (3) @(negedge clk);
    check("rst_a_outputs", {56'd0, a_state_ready, a_perm_req, a_dout_valid, a_dout_last,
                            a_busy, a_done, |a_state_out, |a_dout}, 64'd0);
    check("rst_b_outputs", {56'd0, b_state_ready, b_perm_req, b_dout_valid, b_dout_last,
                            b_busy, b_done, |b_state_out, |b_dout}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 12; t++) run_job(tbl[t]);

    // Reset asserted between clock edges while words are streaming.
    begin
      int words;
      bit seen;
      words = 0;
      seen = 0;
      sel = 1'b0;
      out_len = 10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 50 && words < 3; c++) begin
        if (a_state_ready && !state_valid) begin
          for (int k = 0; k < 25; k++) state_in[1599-k*64 -: 64] = 64'(500 + k);
          state_valid = 1'b1;
        end else if (!a_state_ready) begin
          state_valid = 1'b0;
        end
        dout_ready = 1'b1;
        if (a_dout_valid) words++;
        @(negedge clk);
      end
      check("reset_test_reached_emit", 64'(words), 64'd3);
      check("reset_test_emitting", {63'd0, a_dout_valid}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_outputs", {56'd0, a_state_ready, a_perm_req, a_dout_valid, a_dout_last,
                                  a_busy, a_done, |a_state_out, |a_dout}, 64'd0);
      dout_ready = 1'b0;
      state_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (a_done) seen = 1;
      end
      rst_n = 1'b1;
      @(negedge clk);
      if (a_done) seen = 1;
      check("no_done_after_abort", {63'd0, seen}, 64'd0);
      check("idle_after_abort", {63'd0, a_busy}, 64'd0);
    end

    run_job('{0, 5, 100, 1'b1, 1'b0, 1, 0});
    run_job('{0, 23, 90, 1'b0, 1'b0, 2, 1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
